registers_bank: RTL
===================

# registers_bank

Parametrised general-purpose register bank for the MIPS IV datapath. It sits between ID (two operand reads) and WB (one write). It also serves the debug unit, which reads out the whole bank over a valid/ready stream. Compared with the previous bank it adds:
- a single clock edge with write-to-read bypass;
- register 0 hardwired to zero;
- a sequenced clear after reset, with a busy flag;
- a dump engine for the debug UART path.

## Interface
Parameters:
- registers_width, 32, bits per register (≥1).
- memory_depth, 32, number of registers; power of two, ≥2. Address width is $clog2(memory_depth), called AW below.

Ports (reset is synchronous and active-high, sampled on the rising edge of clk):
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- control_write  in  1  write enable from WB.
- write_register  in  AW  write address.
- write_data  in  registers_width  write value.
- read_register1  in  AW  read port 1 address.
- read_register2  in  AW  read port 2 address.
- read_data1  out  registers_width  registered read port 1 data.
- read_data2  out  registers_width  registered read port 2 data.
- busy  out  1  high while the clear sequence runs.
- dump_start  in  1  single-cycle request to stream out the bank.
- dump_valid  out  1  dump_data/dump_addr are valid.
- dump_ready  in  1  consumer accepts the current entry.
- dump_addr  out  AW  index of the entry being presented.
- dump_data  out  registers_width  content of registers[dump_addr].
- dump_done  out  1  one-cycle pulse after the last entry is accepted.

## Operation
State machine: CLEAR, IDLE, DUMP.

Reset (any state, any cycle):
- next state is CLEAR, clear index = 0.
- read_data1, read_data2 = 0; dump_valid = 0; dump_done = 0; dump_addr = 0.
- busy = 1 from the cycle after reset is sampled.
- An in-progress dump is aborted with no dump_done.

CLEAR:
- Each cycle writes 0 to registers[index] and increments index.
- After index memory_depth-1 is cleared, go to IDLE. busy drops on the first IDLE cycle.
- Writes are ignored. read_data1/2 register 0. dump_start is ignored.

IDLE / DUMP, write port:
- If control_write=1 and write_register≠0, then registers[write_register] ← write_data on the edge.
- A write to register 0 is discarded; register 0 always reads 0.

IDLE / DUMP, read ports:
- read_dataN ← (read_registerN==0) ? 0 : bypass ? write_data : registers[read_registerN].
- bypass = control_write && write_register==read_registerN. A same-cycle write is therefore visible at the next edge, with no stale value.

IDLE → DUMP:
- Taken on dump_start=1. On entry: dump_addr=0, dump_valid=1.

DUMP:
- dump_data is combinational from registers[dump_addr] and is never bypassed. A write to the presented entry is reflected the cycle after it commits.
- The handshake completes when dump_valid && dump_ready. Then:
  - if dump_addr < memory_depth-1: dump_addr+1, dump_valid stays 1;
  - if dump_addr == memory_depth-1: dump_valid=0, dump_done=1 for one cycle, go to IDLE.
- dump_valid is never deasserted without acceptance; dump_addr holds while dump_ready=0.
- dump_start during DUMP is ignored.

## Timing
- Read latency: 1 cycle (address sampled at edge N, data visible after edge N).
- Write: commits at the edge where control_write=1; a read of the same address in a later cycle sees the new value.
- Clear: busy is high for exactly memory_depth cycles after the reset cycle. The first accepted write is on cycle memory_depth+1 after reset deasserts at the edge.
- Dump throughput: one entry per cycle with dump_ready held high. A full dump takes memory_depth cycles from the first valid cycle; dump_done comes on the edge after the last handshake.
- Simultaneous write + dump of the same index: dump_data shows the old value in that cycle and the new value afterwards.

## Test plan
- Reset, then hold idle → busy=1 for 32 cycles, then 0. read_data1/2=0 throughout. Reading any address after clear returns 0.
- Write 0xDEADBEEF to r5 while read_register1=5 in the same cycle → read_data1=0xDEADBEEF after that edge (bypass). read_register2=5 next cycle → 0xDEADBEEF.
- Write 0x12345678 to r0, then read r0 on both ports → 0x00000000, with and without bypass.
- Load rK=K·0x01010101, then dump_start with dump_ready always 1 → 32 handshakes, addresses 0..31, data matches (r0=0). dump_done pulses once, one cycle after address 31 is accepted.
- Dump with dump_ready toggling 1,0,0,1,… → dump_addr/dump_data hold while ready=0. No entry is skipped or duplicated.
- Assert reset at dump_addr=10 → dump_valid=0 next cycle, no dump_done, busy=1, and the bank reads all zeros after the clear completes.

Source files
------------

// File: rtl/registers_bank_if.sv
// Debug dump stream of the register bank: start request, valid/ready entry
// stream and the completion pulse.
interface registers_bank_if #(
  parameter int registers_width = 32,
  parameter int memory_depth    = 32
);
  localparam int AW = $clog2(memory_depth);

  logic                       dump_start;
  logic                       dump_valid;
  logic                       dump_ready;
  logic [AW-1:0]              dump_addr;
  logic [registers_width-1:0] dump_data;
  logic                       dump_done;

  modport master (
    output dump_start,
    output dump_ready,
    input  dump_valid,
    input  dump_addr,
    input  dump_data,
    input  dump_done
  );

  modport slave (
    input  dump_start,
    input  dump_ready,
    output dump_valid,
    output dump_addr,
    output dump_data,
    output dump_done
  );
endinterface

// File: rtl/registers_bank.sv
// MIPS IV general-purpose register bank: two registered read ports with write
// bypass, one write port, r0 hardwired to zero, post-reset clear and dump engine.
module registers_bank #(
  parameter  int registers_width = 32,
  parameter  int memory_depth    = 32,
  localparam int AW              = $clog2(memory_depth)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       control_write,
  input  logic [AW-1:0]              write_register,
  input  logic [registers_width-1:0] write_data,
  input  logic [AW-1:0]              read_register1,
  input  logic [AW-1:0]              read_register2,
  output logic [registers_width-1:0] read_data1,
  output logic [registers_width-1:0] read_data2,
  output logic                       busy,
  registers_bank_if.slave            dump
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_DUMP
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(memory_depth - 1);

  state_t                     state_reg, state_next;
  logic [AW-1:0]              clear_idx_reg, clear_idx_next;
  logic [AW-1:0]              dump_addr_reg, dump_addr_next;
  logic                       dump_valid_reg, dump_valid_next;
  logic                       dump_done_reg, dump_done_next;
  logic [registers_width-1:0] mem [memory_depth];
  logic                       write_en;
  logic [AW-1:0]              rd_addr [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_CLEAR;
      clear_idx_reg  <= '0;
      dump_addr_reg  <= '0;
      dump_valid_reg <= 1'b0;
      dump_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clear_idx_reg  <= clear_idx_next;
      dump_addr_reg  <= dump_addr_next;
      dump_valid_reg <= dump_valid_next;
      dump_done_reg  <= dump_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    clear_idx_next  = clear_idx_reg;
    dump_addr_next  = dump_addr_reg;
    dump_valid_next = dump_valid_reg;
    dump_done_next  = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clear_idx_next = clear_idx_reg + AW'(1);
        if (clear_idx_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (dump.dump_start) begin
          state_next      = ST_DUMP;
          dump_addr_next  = '0;
          dump_valid_next = 1'b1;
        end
      end
      ST_DUMP: begin
        if (dump_valid_reg && dump.dump_ready) begin
          if (dump_addr_reg == LAST_ADDR) begin
            dump_valid_next = 1'b0;
            dump_done_next  = 1'b1;
            state_next      = ST_IDLE;
          end else begin
            dump_addr_next = dump_addr_reg + AW'(1);
          end
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // The clear sequence owns the write port; r0 is only ever written with zero.
  assign write_en = !reset && (state_reg != ST_CLEAR) && control_write
                    && (write_register != '0);

  always_ff @(posedge clk) begin
    if (state_reg == ST_CLEAR) begin
      mem[clear_idx_reg] <= '0;
    end else if (write_en) begin
      mem[write_register] <= write_data;
    end
  end

  assign rd_addr[0] = read_register1;
  assign rd_addr[1] = read_register2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      logic [registers_width-1:0] data_reg;

      // A same-edge write to the addressed register is forwarded so the port never returns stale data.
      always_ff @(posedge clk) begin
        if (reset || (state_reg == ST_CLEAR) || (rd_addr[gi] == '0)) begin
          data_reg <= '0;
        end else if (control_write && (write_register == rd_addr[gi])) begin
          data_reg <= write_data;
        end else begin
          data_reg <= mem[rd_addr[gi]];
        end
      end
    end
  endgenerate

  assign read_data1 = g_read[0].data_reg;
  assign read_data2 = g_read[1].data_reg;
  assign busy       = (state_reg == ST_CLEAR);

  // Dump data reads the array directly, so a write shows up only after it commits.
  assign dump.dump_valid = dump_valid_reg;
  assign dump.dump_addr  = dump_addr_reg;
  assign dump.dump_data  = mem[dump_addr_reg];
  assign dump.dump_done  = dump_done_reg;

endmodule
